// File: rtl/pspin_hostmem_dma_pkg.sv
// Shared definitions for the hostmem DMA arbiters: completion error codes,
// port-index sizing and the engine-side tag format {port index, requester tag}.
package pspin_hostmem_dma_pkg;

  // Completion error code for a clean transfer; other codes pass through uninterpreted.
  localparam logic [3:0] DMA_ERROR_NONE = 4'h0;

  // Widest engine-side tag the pack/unpack helpers can carry.
  localparam int unsigned TAG_BUS_WIDTH = 64;
  typedef logic [TAG_BUS_WIDTH-1:0] tag_bus_t;

  // Bits needed to name one of num_ports requesters (at least 1).
  function automatic int unsigned port_idx_width(input int unsigned num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

  // Mask selecting the requester-tag field (the low s_tag_width bits).
  function automatic tag_bus_t tag_low_mask(input int unsigned s_tag_width);
    return (tag_bus_t'(1) << s_tag_width) - tag_bus_t'(1);
  endfunction

  // Prepend the port index above the requester tag.
  function automatic tag_bus_t tag_pack(input int unsigned port, input tag_bus_t s_tag,
                                        input int unsigned s_tag_width);
    return (tag_bus_t'(port) << s_tag_width) | (s_tag & tag_low_mask(s_tag_width));
  endfunction

  // Port index carried in the upper bits of an engine-side tag.
  function automatic int unsigned tag_port(input tag_bus_t m_tag, input int unsigned s_tag_width);
    return 32'(m_tag >> s_tag_width);
  endfunction

  // Requester tag carried in the lower bits of an engine-side tag.
  function automatic tag_bus_t tag_strip(input tag_bus_t m_tag, input int unsigned s_tag_width);
    return m_tag & tag_low_mask(s_tag_width);
  endfunction

endpackage

// File: rtl/pspin_rr_select.sv
// Combinational round-robin pick: first asserted request at or above ptr_i,
// wrapping past the top. N must be a power of two so the index wraps for free.
module pspin_rr_select
  import pspin_hostmem_dma_pkg::*;
#(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = port_idx_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  logic [IW-1:0] cand;

  // Scan from the farthest offset down so the nearest request to ptr_i wins last.
  always_comb begin
    // NOTE: every output gets a default before the loop, otherwise a path that
    // assigns nothing would infer a latch.
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = ptr_i + IW'(k);
      if (req_i[cand]) begin
        gnt_o        = '0;
        gnt_o[cand]  = 1'b1;
        idx_o        = cand;
        valid_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pspin_hostmem_dma_rd_arb.sv
// Round-robin arbiter sharing one host-memory DMA read descriptor/status channel
// among NUM_PORTS requesters, with a per-port cap on descriptors in flight.
module pspin_hostmem_dma_rd_arb
  import pspin_hostmem_dma_pkg::*;
#(
  parameter int unsigned NUM_PORTS       = 4,
  parameter int unsigned ADDR_WIDTH      = 64,
  parameter int unsigned RAM_SEL_WIDTH   = 4,
  parameter int unsigned RAM_ADDR_WIDTH  = 20,
  parameter int unsigned DMA_LEN_WIDTH   = 16,
  parameter int unsigned S_TAG_WIDTH     = 8,
  parameter int unsigned M_TAG_WIDTH     = S_TAG_WIDTH + $clog2(NUM_PORTS),
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]     s_axis_read_desc_dma_addr,
  input  logic [NUM_PORTS*RAM_SEL_WIDTH-1:0]  s_axis_read_desc_ram_sel,
  input  logic [NUM_PORTS*RAM_ADDR_WIDTH-1:0] s_axis_read_desc_ram_addr,
  input  logic [NUM_PORTS*DMA_LEN_WIDTH-1:0]  s_axis_read_desc_len,
  input  logic [NUM_PORTS*S_TAG_WIDTH-1:0]    s_axis_read_desc_tag,
  input  logic [NUM_PORTS-1:0]                s_axis_read_desc_valid,
  output logic [NUM_PORTS-1:0]                s_axis_read_desc_ready,
  output logic [NUM_PORTS*S_TAG_WIDTH-1:0]    m_axis_read_desc_status_tag,
  output logic [NUM_PORTS*4-1:0]              m_axis_read_desc_status_error,
  output logic [NUM_PORTS-1:0]                m_axis_read_desc_status_valid,
  output logic [ADDR_WIDTH-1:0]               m_axis_read_desc_dma_addr,
  output logic [RAM_SEL_WIDTH-1:0]            m_axis_read_desc_ram_sel,
  output logic [RAM_ADDR_WIDTH-1:0]           m_axis_read_desc_ram_addr,
  output logic [DMA_LEN_WIDTH-1:0]            m_axis_read_desc_len,
  output logic [M_TAG_WIDTH-1:0]              m_axis_read_desc_tag,
  output logic                                m_axis_read_desc_valid,
  input  logic                                m_axis_read_desc_ready,
  input  logic [M_TAG_WIDTH-1:0]              s_axis_read_desc_status_tag,
  input  logic [3:0]                          s_axis_read_desc_status_error,
  input  logic                                s_axis_read_desc_status_valid,
  output logic                                stat_unexpected_status
);

  localparam int unsigned PW = port_idx_width(NUM_PORTS);
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

  typedef logic [CW-1:0] cnt_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]     addr;
    logic [RAM_SEL_WIDTH-1:0]  ram_sel;
    logic [RAM_ADDR_WIDTH-1:0] ram_addr;
    logic [DMA_LEN_WIDTH-1:0]  len;
    logic [S_TAG_WIDTH-1:0]    tag;
  } s_desc_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]     addr;
    logic [RAM_SEL_WIDTH-1:0]  ram_sel;
    logic [RAM_ADDR_WIDTH-1:0] ram_addr;
    logic [DMA_LEN_WIDTH-1:0]  len;
    logic [M_TAG_WIDTH-1:0]    tag;
  } m_desc_t;

  s_desc_t                s_desc [NUM_PORTS];
  logic [NUM_PORTS-1:0]   eligible;

  m_desc_t                m_desc_q, m_desc_d;
  logic                   m_valid_q, m_valid_d;
  logic [PW-1:0]          rr_q, rr_d;
  cnt_t                   cnt_q [NUM_PORTS];
  cnt_t                   cnt_d [NUM_PORTS];
  logic [S_TAG_WIDTH-1:0] st_tag_q [NUM_PORTS];
  logic [S_TAG_WIDTH-1:0] st_tag_d [NUM_PORTS];
  logic [3:0]             st_err_q [NUM_PORTS];
  logic [3:0]             st_err_d [NUM_PORTS];
  logic [NUM_PORTS-1:0]   st_valid_q, st_valid_d;
  logic                   sticky_q, sticky_d;

  logic [NUM_PORTS-1:0]   sel_gnt;
  logic [PW-1:0]          sel_idx;
  logic                   sel_valid;
  logic                   can_load;
  logic                   grant_fire;
  logic [PW-1:0]          st_port;
  logic                   st_hit;

  // Per-port views of the flattened request buses and status lanes.
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    assign s_desc[i] = {s_axis_read_desc_dma_addr[i*ADDR_WIDTH +: ADDR_WIDTH],
                        s_axis_read_desc_ram_sel[i*RAM_SEL_WIDTH +: RAM_SEL_WIDTH],
                        s_axis_read_desc_ram_addr[i*RAM_ADDR_WIDTH +: RAM_ADDR_WIDTH],
                        s_axis_read_desc_len[i*DMA_LEN_WIDTH +: DMA_LEN_WIDTH],
                        s_axis_read_desc_tag[i*S_TAG_WIDTH +: S_TAG_WIDTH]};
    assign eligible[i] = s_axis_read_desc_valid[i] && (cnt_q[i] < CNT_MAX);
    assign m_axis_read_desc_status_tag[i*S_TAG_WIDTH +: S_TAG_WIDTH] = st_tag_q[i];
    assign m_axis_read_desc_status_error[i*4 +: 4]                   = st_err_q[i];
  end

  pspin_rr_select #(
    .N (NUM_PORTS)
  ) u_rr_select (
    .req_i   (eligible),
    .ptr_i   (rr_q),
    .gnt_o   (sel_gnt),
    .idx_o   (sel_idx),
    .valid_o (sel_valid)
  );

  // The holding register accepts a new descriptor when empty or draining this cycle.
  assign can_load   = !m_valid_q || m_axis_read_desc_ready;
  assign grant_fire = can_load && sel_valid;
  assign s_axis_read_desc_ready = grant_fire ? sel_gnt : '0;

  // A completion only counts when its port has something in flight; otherwise it is dropped.
  assign st_port = PW'(tag_port(tag_bus_t'(s_axis_read_desc_status_tag), S_TAG_WIDTH));
  assign st_hit  = s_axis_read_desc_status_valid && (cnt_q[st_port] != '0);

  // Next state: descriptor register, RR pointer, in-flight counters, status lanes.
  always_comb begin
    m_desc_d   = m_desc_q;
    m_valid_d  = m_valid_q && !m_axis_read_desc_ready;
    rr_d       = rr_q;
    cnt_d      = cnt_q;
    st_tag_d   = st_tag_q;
    st_err_d   = st_err_q;
    st_valid_d = '0;
    sticky_d   = sticky_q || (s_axis_read_desc_status_valid && !st_hit);

    if (grant_fire) begin
      m_desc_d.addr     = s_desc[sel_idx].addr;
      m_desc_d.ram_sel  = s_desc[sel_idx].ram_sel;
      m_desc_d.ram_addr = s_desc[sel_idx].ram_addr;
      m_desc_d.len      = s_desc[sel_idx].len;
      m_desc_d.tag      = M_TAG_WIDTH'(tag_pack(32'(sel_idx),
                                                tag_bus_t'(s_desc[sel_idx].tag), S_TAG_WIDTH));
      m_valid_d         = 1'b1;
      rr_d              = sel_idx + PW'(1);
    end

    for (int i = 0; i < NUM_PORTS; i++) begin
      if ((grant_fire && sel_idx == PW'(i)) && !(st_hit && st_port == PW'(i))) begin
        cnt_d[i] = cnt_q[i] + cnt_t'(1);
      end else if (!(grant_fire && sel_idx == PW'(i)) && (st_hit && st_port == PW'(i))) begin
        cnt_d[i] = cnt_q[i] - cnt_t'(1);
      end
    end

    if (st_hit) begin
      st_valid_d[st_port] = 1'b1;
      st_tag_d[st_port]   = S_TAG_WIDTH'(tag_strip(tag_bus_t'(s_axis_read_desc_status_tag),
                                                   S_TAG_WIDTH));
      st_err_d[st_port]   = s_axis_read_desc_status_error;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the per-port arrays are small and feed outputs that must read 0
      // after reset, so they are reset like any other register.
      m_desc_q   <= '0;
      m_valid_q  <= 1'b0;
      rr_q       <= '0;
      cnt_q      <= '{default: '0};
      st_tag_q   <= '{default: '0};
      st_err_q   <= '{default: DMA_ERROR_NONE};
      st_valid_q <= '0;
      sticky_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      m_desc_q   <= m_desc_d;
      m_valid_q  <= m_valid_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      st_tag_q   <= st_tag_d;
      st_err_q   <= st_err_d;
      st_valid_q <= st_valid_d;
      sticky_q   <= sticky_d;
    end
  end

  assign m_axis_read_desc_dma_addr     = m_desc_q.addr;
  assign m_axis_read_desc_ram_sel      = m_desc_q.ram_sel;
  assign m_axis_read_desc_ram_addr     = m_desc_q.ram_addr;
  assign m_axis_read_desc_len          = m_desc_q.len;
  assign m_axis_read_desc_tag          = m_desc_q.tag;
  assign m_axis_read_desc_valid        = m_valid_q;
  assign m_axis_read_desc_status_valid = st_valid_q;
  assign stat_unexpected_status        = sticky_q;

endmodule

// File: tb/tb_pspin_hostmem_dma_rd_arb.sv
// Randomized scoreboard bench for the hostmem DMA read arbiter.
module tb_pspin_hostmem_dma_rd_arb;

  localparam int NP  = 4;
  localparam int AW  = 64;
  localparam int RSW = 4;
  localparam int RAW = 20;
  localparam int LW  = 16;
  localparam int STW = 8;
  localparam int PW  = 2;
  localparam int MTW = STW + PW;
  localparam int MO  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [NP*AW-1:0]  s_axis_read_desc_dma_addr;
  logic [NP*RSW-1:0] s_axis_read_desc_ram_sel;
  logic [NP*RAW-1:0] s_axis_read_desc_ram_addr;
  logic [NP*LW-1:0]  s_axis_read_desc_len;
  logic [NP*STW-1:0] s_axis_read_desc_tag;
  logic [NP-1:0]     s_axis_read_desc_valid;
  logic [NP-1:0]     s_axis_read_desc_ready;
  logic [NP*STW-1:0] m_axis_read_desc_status_tag;
  logic [NP*4-1:0]   m_axis_read_desc_status_error;
  logic [NP-1:0]     m_axis_read_desc_status_valid;
  logic [AW-1:0]     m_axis_read_desc_dma_addr;
  logic [RSW-1:0]    m_axis_read_desc_ram_sel;
  logic [RAW-1:0]    m_axis_read_desc_ram_addr;
  logic [LW-1:0]     m_axis_read_desc_len;
  logic [MTW-1:0]    m_axis_read_desc_tag;
  logic              m_axis_read_desc_valid;
  logic              m_axis_read_desc_ready;
  logic [MTW-1:0]    s_axis_read_desc_status_tag;
  logic [3:0]        s_axis_read_desc_status_error;
  logic              s_axis_read_desc_status_valid;
  logic              stat_unexpected_status;

  pspin_hostmem_dma_rd_arb #(
    .NUM_PORTS(NP), .ADDR_WIDTH(AW), .RAM_SEL_WIDTH(RSW), .RAM_ADDR_WIDTH(RAW),
    .DMA_LEN_WIDTH(LW), .S_TAG_WIDTH(STW), .M_TAG_WIDTH(MTW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk                           (clk),
    .rst                           (rst),
    .s_axis_read_desc_dma_addr     (s_axis_read_desc_dma_addr),
    .s_axis_read_desc_ram_sel      (s_axis_read_desc_ram_sel),
    .s_axis_read_desc_ram_addr     (s_axis_read_desc_ram_addr),
    .s_axis_read_desc_len          (s_axis_read_desc_len),
    .s_axis_read_desc_tag          (s_axis_read_desc_tag),
    .s_axis_read_desc_valid        (s_axis_read_desc_valid),
    .s_axis_read_desc_ready        (s_axis_read_desc_ready),
    .m_axis_read_desc_status_tag   (m_axis_read_desc_status_tag),
    .m_axis_read_desc_status_error (m_axis_read_desc_status_error),
    .m_axis_read_desc_status_valid (m_axis_read_desc_status_valid),
    .m_axis_read_desc_dma_addr     (m_axis_read_desc_dma_addr),
    .m_axis_read_desc_ram_sel      (m_axis_read_desc_ram_sel),
    .m_axis_read_desc_ram_addr     (m_axis_read_desc_ram_addr),
    .m_axis_read_desc_len          (m_axis_read_desc_len),
    .m_axis_read_desc_tag          (m_axis_read_desc_tag),
    .m_axis_read_desc_valid        (m_axis_read_desc_valid),
    .m_axis_read_desc_ready        (m_axis_read_desc_ready),
    .s_axis_read_desc_status_tag   (s_axis_read_desc_status_tag),
    .s_axis_read_desc_status_error (s_axis_read_desc_status_error),
    .s_axis_read_desc_status_valid (s_axis_read_desc_status_valid),
    .stat_unexpected_status        (stat_unexpected_status)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0]  addr;
    logic [RSW-1:0] sel;
    logic [RAW-1:0] raddr;
    logic [LW-1:0]  len;
    logic [MTW-1:0] tag;
  } mdesc_t;

  typedef struct {
    logic [STW-1:0] tag;
    logic [3:0]     err;
    int             cyc;
  } st_t;

  typedef struct {
    int n;
    int pv;
    int pr;
    int ps;
    int pb;
    bit r;
  } phase_t;

  mdesc_t         exp_m[$];
  st_t            exp_st[NP][$];
  logic [MTW-1:0] inflight[$];
  phase_t         phases[$];

  int n_vec = 0;
  int n_bad = 0;

  // Requester-side pending descriptors.
  logic [AW-1:0]  r_addr [NP];
  logic [RSW-1:0] r_sel  [NP];
  logic [RAW-1:0] r_raddr[NP];
  logic [LW-1:0]  r_len  [NP];
  logic [STW-1:0] r_tag  [NP];
  bit             r_has  [NP];

  // Reference model state: in-flight count per port, next port to favour,
  // whether a descriptor is waiting at the engine, and the sticky flag.
  int             cnt[NP];
  int             rr;
  bit             mv;
  logic [MTW-1:0] mtag;
  bit             sticky;
  int             granted;
  bit             rst_applied;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      cnt[p]   = 0;
      r_has[p] = 1'b0;
      exp_st[p].delete();
    end
    rr      = 0;
    mv      = 1'b0;
    mtag    = '0;
    sticky  = 1'b0;
    granted = -1;
    exp_m.delete();
    inflight.delete();
  endtask

  task automatic drive_inputs();
    for (int p = 0; p < NP; p++) begin
      s_axis_read_desc_dma_addr[p*AW +: AW]   = r_addr[p];
      s_axis_read_desc_ram_sel[p*RSW +: RSW]  = r_sel[p];
      s_axis_read_desc_ram_addr[p*RAW +: RAW] = r_raddr[p];
      s_axis_read_desc_len[p*LW +: LW]        = r_len[p];
      s_axis_read_desc_tag[p*STW +: STW]      = r_tag[p];
      s_axis_read_desc_valid[p]               = r_has[p];
    end
  endtask

  // Choose this cycle's requests, engine readiness and completion.
  task automatic gen_stimulus(input phase_t ph);
    rst = ph.r;
    s_axis_read_desc_status_valid = 1'b0;
    s_axis_read_desc_status_tag   = '0;
    s_axis_read_desc_status_error = '0;
    if (ph.r) begin
      for (int p = 0; p < NP; p++) r_has[p] = 1'b0;
      m_axis_read_desc_ready = 1'b0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        if (!r_has[p] && ($urandom % 100) < ph.pv) begin
          r_has[p]   = 1'b1;
          r_addr[p]  = {$urandom, $urandom};
          r_sel[p]   = RSW'($urandom);
          r_raddr[p] = RAW'($urandom);
          r_len[p]   = LW'($urandom);
          r_tag[p]   = STW'($urandom);
        end
      end
      m_axis_read_desc_ready = (($urandom % 100) < ph.pr);
      if (inflight.size() > 0 && ($urandom % 100) < ph.ps) begin
        int k;
        k = $urandom_range(0, inflight.size() - 1);
        s_axis_read_desc_status_tag   = inflight[k];
        inflight.delete(k);
        s_axis_read_desc_status_valid = 1'b1;
        s_axis_read_desc_status_error = (($urandom % 4) == 0) ? 4'($urandom) : 4'h0;
      end else if (($urandom % 100) < ph.pb) begin
        s_axis_read_desc_status_tag   = {PW'($urandom_range(0, NP - 1)), STW'($urandom)};
        s_axis_read_desc_status_valid = 1'b1;
        s_axis_read_desc_status_error = 4'($urandom);
      end
    end
    drive_inputs();
  endtask

  // Reference step at mid-cycle: check control outputs, then predict the next edge.
  task automatic model_step();
    int             g;
    bit             can_load;
    logic [NP-1:0]  e_ready;
    granted = -1;
    if (rst) begin
      if (rst_applied) begin
        check("reset_ctrl",
              {s_axis_read_desc_ready, m_axis_read_desc_valid, m_axis_read_desc_status_valid,
               stat_unexpected_status, m_axis_read_desc_status_tag, m_axis_read_desc_status_error},
              '0);
        check("reset_desc",
              {m_axis_read_desc_dma_addr, m_axis_read_desc_ram_sel, m_axis_read_desc_ram_addr,
               m_axis_read_desc_len, m_axis_read_desc_tag}, '0);
      end
      return;
    end
    can_load = !mv || m_axis_read_desc_ready;
    g = -1;
    for (int k = 0; k < NP; k++) begin
      int p;
      p = (rr + k) % NP;
      if (g < 0 && r_has[p] && cnt[p] < MO) g = p;
    end
    e_ready = '0;
    if (can_load && g >= 0) e_ready[g] = 1'b1;
    check("s_ready", s_axis_read_desc_ready, e_ready);
    check("m_valid", m_axis_read_desc_valid, mv);
    check("stat_unexpected", stat_unexpected_status, sticky);

    if (s_axis_read_desc_status_valid) begin
      int p;
      p = int'(s_axis_read_desc_status_tag >> STW);
      if (cnt[p] == 0) sticky = 1'b1;
      else begin
        cnt[p]--;
        exp_st[p].push_back('{s_axis_read_desc_status_tag[STW-1:0],
                              s_axis_read_desc_status_error, cyc + 1});
      end
    end
    if (mv && m_axis_read_desc_ready) begin
      inflight.push_back(mtag);
      mv = 1'b0;
    end
    if (can_load && g >= 0) begin
      cnt[g]++;
      mtag = {PW'(g), r_tag[g]};
      exp_m.push_back('{r_addr[g], r_sel[g], r_raddr[g], r_len[g], mtag});
      rr      = (g + 1) % NP;
      mv      = 1'b1;
      granted = g;
    end
  endtask

  // Monitor: whatever the DUT presents is compared with the head of its queue.
  always @(negedge clk) begin
    if (m_axis_read_desc_valid) begin
      if (exp_m.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL m_desc: got tag 0x%0h, expected no descriptor (cycle %0d)",
                 m_axis_read_desc_tag, cyc);
      end else begin
        check("m_desc",
              {m_axis_read_desc_dma_addr, m_axis_read_desc_ram_sel, m_axis_read_desc_ram_addr,
               m_axis_read_desc_len, m_axis_read_desc_tag},
              {exp_m[0].addr, exp_m[0].sel, exp_m[0].raddr, exp_m[0].len, exp_m[0].tag});
        if (m_axis_read_desc_ready) void'(exp_m.pop_front());
      end
    end
    for (int p = 0; p < NP; p++) begin
      if (m_axis_read_desc_status_valid[p]) begin
        if (exp_st[p].size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL status_port%0d: got strobe tag 0x%0h, expected none (cycle %0d)",
                   p, m_axis_read_desc_status_tag[p*STW +: STW], cyc);
        end else begin
          st_t e;
          e = exp_st[p].pop_front();
          check($sformatf("status_port%0d", p),
                {m_axis_read_desc_status_tag[p*STW +: STW],
                 m_axis_read_desc_status_error[p*4 +: 4], 32'(cyc)},
                {e.tag, e.err, 32'(e.cyc)});
        end
      end
    end
  end

  initial begin
    for (int p = 0; p < NP; p++) begin
      r_addr[p] = '0; r_sel[p] = '0; r_raddr[p] = '0; r_len[p] = '0; r_tag[p] = '0;
    end
    model_reset();
    rst_applied = 1'b0;
    m_axis_read_desc_ready = 1'b0;

    //                n    pv   pr   ps  pb  rst
    phases.push_back('{3,   0,   0,   0,  0, 1'b1});
    phases.push_back('{200, 70,  80,  40, 2, 1'b0});  // mixed traffic
    phases.push_back('{100, 100, 100, 0,  0, 1'b0});  // no completions: every port hits its cap
    phases.push_back('{60,  100, 0,   30, 0, 1'b0});  // engine stalled: descriptor held
    phases.push_back('{150, 100, 100, 60, 0, 1'b0});  // saturated round-robin
    phases.push_back('{3,   0,   0,   0,  0, 1'b1});  // reset with work in flight
    phases.push_back('{150, 50,  60,  50, 10, 1'b0}); // includes unexpected completions
    phases.push_back('{2,   0,   0,   0,  0, 1'b1});
    phases.push_back('{40,  80,  90,  50, 0, 1'b0});
    phases.push_back('{80,  0,   100, 100, 0, 1'b0}); // drain

    foreach (phases[i]) begin
      for (int c = 0; c < phases[i].n; c++) begin
        gen_stimulus(phases[i]);
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
        if (rst) begin
          model_reset();
          rst_applied = 1'b1;
        end else begin
          rst_applied = 1'b0;
          if (granted >= 0) r_has[granted] = 1'b0;
        end
      end
    end

    @(negedge clk);
    check("drain_desc_queue", 128'(exp_m.size()), 128'(0));
    for (int p = 0; p < NP; p++) begin
      check($sformatf("drain_status_queue_port%0d", p), 128'(exp_st[p].size()), 128'(0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
